// File: rtl/huffman_seq.sv
// Sequential Huffman encoder: table lookup, one code bit per cycle, packed into nibbles.
// Optional statistics counters are enabled by defining HUFF_STATS_EN.
module huffman_seq #(
  parameter int SYM_W   = 4,
  parameter int MAX_LEN = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CFG_WE,
  input  logic [SYM_W-1:0]   CFG_ADDR,
  input  logic [MAX_LEN-1:0] CFG_CODE,
  input  logic [3:0]         CFG_LEN,
  input  logic               SYM_VALID,
  input  logic [SYM_W-1:0]   SYM_DATA,
  output logic               SYM_READY,
  input  logic               FLUSH,
  output logic               OUT_VALID,
  output logic [3:0]         OUT_DATA,
  input  logic               OUT_READY,
  output logic               BUSY,
  output logic               ERR,
  output logic [15:0]        SYM_CNT,
  output logic [15:0]        NIB_CNT
);

  localparam int DEPTH = 1 << SYM_W;

  typedef enum logic [1:0] {IDLE, SHIFT, EMIT, PAD} state_t;

  state_t             state, state_nx;
  logic [MAX_LEN-1:0] code_tbl [DEPTH];
  logic [3:0]         len_tbl  [DEPTH];
  logic [MAX_LEN-1:0] sreg;
  logic [3:0]         rem;
  logic [3:0]         acc;
  logic [2:0]         fill;
  logic               err_q;
  logic [MAX_LEN-1:0] sel_code;
  logic [3:0]         sel_len;
  logic               accept;
  logic               out_hs;
  logic [1:0]         bit_idx;

  // Left-align a right-aligned code so its first bit sits at the shift-register MSB.
  function automatic logic [MAX_LEN-1:0] align_code(input logic [MAX_LEN-1:0] code,
                                                    input logic [3:0] len);
    logic [4:0] sh;
    sh = 5'(MAX_LEN) - {1'b0, len};
    return code << sh;
  endfunction

  // Keep only the filled high bits of a partial nibble.
  function automatic logic [3:0] pad_nib(input logic [3:0] nib, input logic [2:0] f);
    logic [3:0] m;
    m = 4'b1111 << (3'd4 - f);
    return nib & m;
  endfunction

  // Table reads are combinational, so a same-cycle write still yields the old entry.
  assign sel_code = code_tbl[SYM_DATA];
  assign sel_len  = len_tbl[SYM_DATA];
  assign accept   = (state == IDLE) && SYM_VALID;
  assign out_hs   = (state == EMIT) && OUT_READY;
  assign bit_idx  = 2'd3 - fill[1:0];

  assign SYM_READY = (state == IDLE);
  assign BUSY      = (state != IDLE);
  assign OUT_VALID = (state == EMIT);
  assign OUT_DATA  = (state == EMIT) ? acc : 4'd0;
  assign ERR       = err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) len_tbl[i] <= '0;
    end else if (CFG_WE) begin
      len_tbl[CFG_ADDR] <= CFG_LEN;
    end
  end

  always_ff @(posedge CLK) begin
    if (CFG_WE) code_tbl[CFG_ADDR] <= CFG_CODE;
  end

  always_ff @(posedge CLK) begin
    if (accept) sreg <= align_code(sel_code, sel_len);
    else if (state == SHIFT) sreg <= sreg << 1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (SYM_VALID) begin
          if (sel_len != 4'd0) state_nx = SHIFT;
        end else if (FLUSH && (fill != 3'd0)) begin
          state_nx = PAD;
        end
      end
      SHIFT: begin
        if (fill == 3'd3)     state_nx = EMIT;
        else if (rem == 4'd1) state_nx = IDLE;
      end
      EMIT: begin
        if (OUT_READY) state_nx = (rem != 4'd0) ? SHIFT : IDLE;
      end
      PAD:     state_nx = EMIT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      fill  <= '0;
      rem   <= '0;
      acc   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= accept && (sel_len == 4'd0);
      case (state)
        IDLE: begin
          if (accept && (sel_len != 4'd0)) rem <= sel_len;
        end
        SHIFT: begin
          acc[bit_idx] <= sreg[MAX_LEN-1];
          fill         <= fill + 3'd1;
          rem          <= rem - 4'd1;
        end
        EMIT: begin
          if (OUT_READY) begin
            fill <= '0;
            acc  <= '0;
          end
        end
        PAD: begin
          acc  <= pad_nib(acc, fill);
          fill <= 3'd4;
        end
        default: ;
      endcase
    end
  end

`ifdef HUFF_STATS_EN
  logic [15:0] sym_cnt, nib_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sym_cnt <= '0;
      nib_cnt <= '0;
    end else begin
      if (accept) sym_cnt <= sym_cnt + 16'd1;
      if (out_hs) nib_cnt <= nib_cnt + 16'd1;
    end
  end

  assign SYM_CNT = sym_cnt;
  assign NIB_CNT = nib_cnt;
`else
  logic unused_hs;
  assign unused_hs = out_hs;
  assign SYM_CNT   = 16'd0;
  assign NIB_CNT   = 16'd0;
`endif

endmodule

// File: tb/tb_huffman_seq.sv
// Directed self-checking bench for huffman_seq; inputs change and outputs are sampled on negedge.
module tb_huffman_seq;

  logic        CLK = 1'b0;
  logic        RST, CFG_WE, SYM_VALID, FLUSH, OUT_READY;
  logic [3:0]  CFG_ADDR, CFG_LEN, SYM_DATA;
  logic [7:0]  CFG_CODE;
  logic        SYM_READY, OUT_VALID, BUSY, ERR;
  logic [3:0]  OUT_DATA;
  logic [15:0] SYM_CNT, NIB_CNT;

  int n_assert = 0;
  int n_fail   = 0;

  huffman_seq #(.SYM_W(4), .MAX_LEN(8)) dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_CODE(CFG_CODE),
    .CFG_LEN(CFG_LEN), .SYM_VALID(SYM_VALID), .SYM_DATA(SYM_DATA), .SYM_READY(SYM_READY),
    .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY),
    .BUSY(BUSY), .ERR(ERR), .SYM_CNT(SYM_CNT), .NIB_CNT(NIB_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [3:0] addr, input logic [7:0] code, input logic [3:0] len);
    CFG_WE = 1'b1; CFG_ADDR = addr; CFG_CODE = code; CFG_LEN = len;
    step();
    CFG_WE = 1'b0;
  endtask

  task automatic send(input logic [3:0] sym);
    SYM_VALID = 1'b1; SYM_DATA = sym;
    step();
    SYM_VALID = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; CFG_WE = 1'b0; SYM_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b1;
    CFG_ADDR = '0; CFG_LEN = '0; SYM_DATA = '0; CFG_CODE = '0;
    @(negedge CLK);
    steps(2);
    chk_b("rst_out_valid", OUT_VALID, 1'b0);
    chk_w("rst_out_data", 16'(OUT_DATA), 16'h0);
    chk_b("rst_sym_ready", SYM_READY, 1'b1);
    chk_b("rst_busy", BUSY, 1'b0);
    chk_b("rst_err", ERR, 1'b0);
    chk_w("rst_sym_cnt", SYM_CNT, 16'h0);
    chk_w("rst_nib_cnt", NIB_CNT, 16'h0);
    RST = 1'b0;

    // sym2 = 101, sym5 = 11 -> nibble 1011 with one bit left over
    cfg(4'd2, 8'b101, 4'd3);
    cfg(4'd5, 8'b11, 4'd2);
    send(4'd2);
    chk_b("s2_busy", BUSY, 1'b1);
    chk_b("s2_ready_low", SYM_READY, 1'b0);
    steps(3);
    chk_b("s2_idle_ready", SYM_READY, 1'b1);
    chk_b("s2_no_out", OUT_VALID, 1'b0);
    send(4'd5);
    step();
    chk_b("n1_valid", OUT_VALID, 1'b1);
    chk_w("n1_data", 16'(OUT_DATA), 16'hB);
    step();
    chk_b("n1_done", OUT_VALID, 1'b0);
    chk_b("n1_shift_busy", BUSY, 1'b1);
    step();
    chk_b("s5_idle_busy", BUSY, 1'b0);
    chk_b("s5_idle_ready", SYM_READY, 1'b1);

    // Flush the single pending bit
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk_b("pad_busy", BUSY, 1'b1);
    chk_b("pad_no_out", OUT_VALID, 1'b0);
    step();
    chk_b("flush_valid", OUT_VALID, 1'b1);
    chk_w("flush_data", 16'(OUT_DATA), 16'h8);
    step();
    chk_b("flush_done_busy", BUSY, 1'b0);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk_b("flush_empty_noop", BUSY, 1'b0);
    chk_b("flush_empty_noout", OUT_VALID, 1'b0);

    // 8-bit code A5 with back-pressure
    cfg(4'd0, 8'hA5, 4'd8);
    OUT_READY = 1'b0;
    send(4'd0);
    steps(3);
    chk_b("a5_lat_early", OUT_VALID, 1'b0);
    step();
    chk_b("a5_hi_valid", OUT_VALID, 1'b1);
    chk_w("a5_hi_data", 16'(OUT_DATA), 16'hA);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_b("a5_hold_valid", OUT_VALID, 1'b1);
      chk_w("a5_hold_data", 16'(OUT_DATA), 16'hA);
      chk_b("a5_hold_ready", SYM_READY, 1'b0);
    end
    OUT_READY = 1'b1;
    step();
    chk_b("a5_mid_ready", SYM_READY, 1'b0);
    chk_b("a5_mid_novalid", OUT_VALID, 1'b0);
    steps(3);
    chk_b("a5_lo_ready", SYM_READY, 1'b0);
    step();
    chk_b("a5_lo_valid", OUT_VALID, 1'b1);
    chk_w("a5_lo_data", 16'(OUT_DATA), 16'h5);
    step();
    chk_b("a5_end_ready", SYM_READY, 1'b1);
`ifdef HUFF_STATS_EN
    chk_w("cnt_sym_3", SYM_CNT, 16'd3);
    chk_w("cnt_nib_4", NIB_CNT, 16'd4);
`else
    chk_w("cnt_sym_off", SYM_CNT, 16'd0);
    chk_w("cnt_nib_off", NIB_CNT, 16'd0);
`endif

    // Unconfigured symbol -> ERR pulse
    send(4'd7);
    chk_b("err_high", ERR, 1'b1);
    chk_b("err_idle", SYM_READY, 1'b1);
    chk_b("err_noout", OUT_VALID, 1'b0);
    step();
    chk_b("err_pulse_end", ERR, 1'b0);
    chk_b("err_noout2", OUT_VALID, 1'b0);
    chk_b("err_busy", BUSY, 1'b0);
`ifdef HUFF_STATS_EN
    chk_w("cnt_sym_err", SYM_CNT, 16'd4);
`endif

    // Same-cycle table write while sym3 is accepted
    cfg(4'd3, 8'b0110, 4'd4);
    CFG_WE = 1'b1; CFG_ADDR = 4'd3; CFG_CODE = 8'b1001; CFG_LEN = 4'd4;
    send(4'd3);
    CFG_WE = 1'b0;
    steps(4);
    chk_b("old_valid", OUT_VALID, 1'b1);
    chk_w("old_data", 16'(OUT_DATA), 16'h6);
    step();
    chk_b("old_done", BUSY, 1'b0);
    send(4'd3);
    steps(4);
    chk_b("new_valid", OUT_VALID, 1'b1);
    chk_w("new_data", 16'(OUT_DATA), 16'h9);
    step();

    // Reset while holding a nibble in EMIT
    OUT_READY = 1'b0;
    send(4'd3);
    steps(4);
    chk_b("pre_rst_valid", OUT_VALID, 1'b1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk_b("post_rst_valid", OUT_VALID, 1'b0);
    chk_w("post_rst_data", 16'(OUT_DATA), 16'h0);
    chk_b("post_rst_ready", SYM_READY, 1'b1);
    chk_b("post_rst_busy", BUSY, 1'b0);
    chk_w("post_rst_sym_cnt", SYM_CNT, 16'h0);
    chk_w("post_rst_nib_cnt", NIB_CNT, 16'h0);
    OUT_READY = 1'b1;
    send(4'd3);
    chk_b("post_rst_err", ERR, 1'b1);
    chk_b("post_rst_err_idle", BUSY, 1'b0);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk_b("post_rst_nopending", BUSY, 1'b0);
    chk_b("post_rst_noout", OUT_VALID, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/huffman_seq.md
HUFFMAN_SEQ -- requirements
Module: huffman_seq

Interface
REQ-001 The module SHALL have parameter SYM_W, default 4, meaning symbol width (2^SYM_W code-table entries).
REQ-002 The module SHALL have parameter MAX_LEN, default 8, meaning maximum code length in bits.
REQ-003 The module SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port CFG_WE, input, 1 bit: code-table write strobe.
REQ-006 The module SHALL have port CFG_ADDR, input, SYM_W bits: table entry index.
REQ-007 The module SHALL have port CFG_CODE, input, MAX_LEN bits: code right-aligned in the low CFG_LEN bits.
REQ-008 The module SHALL have port CFG_LEN, input, 4 bits: code length 1..MAX_LEN, with 0 meaning entry invalid.
REQ-009 The module SHALL have ports SYM_VALID (input, 1 bit), SYM_DATA (input, SYM_W bits) and SYM_READY (output, 1 bit): the symbol handshake.
REQ-010 The module SHALL have port FLUSH, input, 1 bit: level request to pad and emit a partial nibble.
REQ-011 The module SHALL have ports OUT_VALID (output, 1 bit), OUT_DATA (output, 4 bits) and OUT_READY (input, 1 bit): the packed-nibble output handshake.
REQ-012 The module SHALL have ports BUSY (output, 1 bit, state != IDLE) and ERR (output, 1 bit, one-cycle invalid-symbol pulse).
REQ-013 The module SHALL have ports SYM_CNT (output, 16 bits) and NIB_CNT (output, 16 bits): statistics, see Configuration.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, SHIFT, EMIT and PAD.
REQ-015 SYM_READY SHALL be 1 only in IDLE; a symbol is accepted on SYM_VALID && SYM_READY.
REQ-016 On accept, CODE/LEN for SYM_DATA SHALL be latched into a shift register and remaining-bit counter; a CFG write to the same address in the same cycle SHALL NOT affect the latched value (old entry used).
REQ-017 Accepting an entry with LEN=0 SHALL consume the symbol, pulse ERR for 1 cycle, emit no bits and stay in IDLE.
REQ-018 In SHIFT, one code bit per cycle, MSB of the code first, SHALL enter the accumulator at position 3-fill, incrementing fill and decrementing remaining.
REQ-019 SHIFT SHALL go to EMIT when fill reaches 4; otherwise, when remaining reaches 0, it SHALL go to IDLE with the partial fill retained.
REQ-020 In EMIT, OUT_VALID=1 and OUT_DATA=accumulator SHALL be held stable until OUT_READY; on handshake fill SHALL clear and the FSM SHALL go to SHIFT if remaining>0, else IDLE.
REQ-021 Latency: a symbol accepted at cycle t SHALL have its first bit in the accumulator at t+1, with a full nibble visible on OUT_VALID the cycle after the 4th bit.
REQ-022 In IDLE, FLUSH=1 with SYM_VALID=0 and fill>0 SHALL go to PAD, which zero-fills the unused low bits in one cycle and then goes to EMIT.
REQ-023 FLUSH with fill=0 SHALL be a no-op, and SYM_VALID SHALL take priority over FLUSH.
REQ-024 CFG writes SHALL be accepted in any state.

Reset
REQ-025 When RST=1 the FSM SHALL enter IDLE, with fill, remaining and accumulator cleared, OUT_VALID=0, OUT_DATA=0, ERR=0, BUSY=0, SYM_READY=1 from the first post-reset cycle, all table LEN cleared to 0 and the counters cleared.
REQ-026 RST asserted mid-symbol or mid-EMIT SHALL discard the pending bits without emitting them.

Configuration
REQ-027 Macro HUFF_STATS_EN defined SHALL make SYM_CNT increment on every accepted symbol (including ERR symbols) and NIB_CNT increment on every OUT handshake, both wrapping at 16'hFFFF to 0.
REQ-028 Macro HUFF_STATS_EN undefined SHALL tie SYM_CNT and NIB_CNT to 0 and generate no counter logic; the port list SHALL be unchanged.

Verification
REQ-029 The bench SHALL cover: table sym2=101/len3 and sym5=11/len2, send 2 then 5 with OUT_READY=1 -> one nibble 4'b1011, with 1 bit pending and BUSY=0 afterwards.
REQ-030 The bench SHALL cover: continuing the previous case with FLUSH=1 -> PAD, then OUT_DATA=4'b1000 and fill=0.
REQ-031 The bench SHALL cover: sym0 len8 code 8'hA5 with OUT_READY=0 for 5 cycles -> OUT_DATA=4'hA held stable, then 4'h5, with SYM_READY=0 throughout.
REQ-032 The bench SHALL cover: sending a symbol whose LEN=0 -> ERR high exactly 1 cycle, no OUT_VALID, SYM_CNT+1 (with the macro defined).
REQ-033 The bench SHALL cover: CFG write of new code to sym3 in the same cycle sym3 is accepted -> old code emitted; the next sym3 uses the new code.
REQ-034 The bench SHALL cover: RST during EMIT -> next cycle OUT_VALID=0, SYM_READY=1, counters 0, any previously loaded symbol flagged ERR.
